// File: rtl/VX_gpu_pkg.sv
// Shared LSU definitions: fence sequencer states and the default outstanding-store limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package VX_gpu_pkg;

  // Default per-warp limit on stores in flight to the memory interface.
  localparam int PENDING_STORES_MAX = 15;

  // Fence sequencer: wait for a fence, drain its warp, then present fence_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fence_state_t;

endpackage

// File: rtl/lsu_pending_counter.sv
// Saturating up/down counter of one warp's stores that are still waiting for an ack.
// Latency: count, is_zero and is_full change 1 cycle after inc/dec. ovf/unf are same-cycle pulses.
// Backpressure: none. is_full is what the parent uses to stall further stores.
// Ports: clk, reset (sync, active-high), inc (store fired), dec (ack returned),
//        count, is_zero, is_full, ovf (inc at full), unf (dec at zero).
module lsu_pending_counter
  import VX_gpu_pkg::*;
#(
  parameter int MAX_PENDING = PENDING_STORES_MAX,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_full,
  output logic             ovf,
  output logic             unf
);

  logic [CNT_W-1:0] cnt_q;

  assign count   = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_full = (cnt_q == CNT_W'(MAX_PENDING));

  // A store and an ack in the same cycle cancel. This holds even at the limits,
  // so neither of them is flagged as an error.
  assign ovf = inc & ~dec & is_full;
  assign unf = dec & ~inc & is_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && !dec && !is_full) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && !is_zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/lsu_store_fence_ctrl.sv
// Per-warp outstanding-store tracker and fence sequencer between issue and the LSU.
// Latency: counts/status 1 cycle after a store or ack. A fence on a drained warp is ready 2 cycles after fence_valid.
// Backpressure: st_stall_mask blocks a warp at its limit, and fence_ready is held low until the warp drains.
// Ports: clk, reset (sync, active-high); st_fire/st_wid and ack_valid/ack_wid feed the counters;
//        fence_valid/fence_wid/fence_ready form the fence handshake; st_stall_mask, no_pending_stores
//        and the sticky err_overflow/err_underflow flags are status. Every output is a function of registers only.
module lsu_store_fence_ctrl
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int MAX_PENDING = PENDING_STORES_MAX,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1),
  parameter int WID_W       = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_fire,
  input  logic [WID_W-1:0]     st_wid,
  input  logic                 ack_valid,
  input  logic [WID_W-1:0]     ack_wid,
  input  logic                 fence_valid,
  input  logic [WID_W-1:0]     fence_wid,
  output logic                 fence_ready,
  output logic [NUM_WARPS-1:0] st_stall_mask,
  output logic                 no_pending_stores,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  logic [CNT_W-1:0]     cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] zero_vec;
  logic [NUM_WARPS-1:0] full_vec;
  logic [NUM_WARPS-1:0] ovf_vec;
  logic [NUM_WARPS-1:0] unf_vec;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    lsu_pending_counter #(
      .MAX_PENDING (MAX_PENDING),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (st_fire   && (st_wid  == WID_W'(w))),
      .dec     (ack_valid && (ack_wid == WID_W'(w))),
      .count   (cnt[w]),
      .is_zero (zero_vec[w]),
      .is_full (full_vec[w]),
      .ovf     (ovf_vec[w]),
      .unf     (unf_vec[w])
    );
  end

  assign st_stall_mask     = full_vec;
  assign no_pending_stores = &zero_vec;

  // Only one warp is updated on each side per cycle, so the per-warp pulses can simply be OR-ed together.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow  | (|ovf_vec);
      err_underflow <= err_underflow | (|unf_vec);
    end
  end

  // Fence sequencer. Only one fence is in flight at a time across the core.
  fence_state_t     state, state_nxt;
  logic [WID_W-1:0] f_wid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fence_valid) state_nxt = DRAIN;
      DRAIN:   if (cnt[f_wid] == '0) state_nxt = DONE;
      // DONE always lasts one cycle. This covers a normal handshake and also
      // recovers when issue has dropped fence_valid early.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      f_wid <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fence_valid) f_wid <= fence_wid;
    end
  end

  assign fence_ready = (state == DONE);

endmodule

// File: tb/tb_lsu_store_fence_ctrl.sv
module tb_lsu_store_fence_ctrl;
  import VX_gpu_pkg::*;

  localparam int NW = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_fire;
  logic [WW-1:0] st_wid;
  logic          ack_valid;
  logic [WW-1:0] ack_wid;
  logic          fence_valid;
  logic [WW-1:0] fence_wid;
  logic          fence_ready;
  logic [NW-1:0] st_stall_mask;
  logic          no_pending_stores;
  logic          err_overflow;
  logic          err_underflow;

  lsu_store_fence_ctrl #(.NUM_WARPS(NW), .MAX_PENDING(15)) dut (
    .clk               (clk),
    .reset             (reset),
    .st_fire           (st_fire),
    .st_wid            (st_wid),
    .ack_valid         (ack_valid),
    .ack_wid           (ack_wid),
    .fence_valid       (fence_valid),
    .fence_wid         (fence_wid),
    .fence_ready       (fence_ready),
    .st_stall_mask     (st_stall_mask),
    .no_pending_stores (no_pending_stores),
    .err_overflow      (err_overflow),
    .err_underflow     (err_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit acc   = 0;
  int exp_q[$];   // expected cycle numbers at which fence_ready should appear

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Move into the next cycle: inputs may be driven right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs at the negedge. When fence_ready is high, it takes the next entry from the scoreboard.
  task automatic mon();
    if (fence_ready) begin
      if (exp_q.size() == 0) chk("fence_spurious", fence_ready, 0);
      else                   chk("fence_lat", cyc, exp_q.pop_front());
      acc = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1; st_fire = 0; st_wid = 0; ack_valid = 0; ack_wid = 0;
    fence_valid = 0; fence_wid = 0;
    tick(); tick();
    reset = 0; cyc = 0; acc = 0;
    exp_q.delete();
  endtask

  initial begin
    // Reset state, then 5 idle cycles.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      chk("rst_nps", no_pending_stores, 1);
      chk("rst_mask", st_stall_mask, 0);
      chk("rst_ready", fence_ready, 0);
      chk("rst_ovf", err_overflow, 0);
      chk("rst_unf", err_underflow, 0);
    end

    // 3 stores on warp 1 (cycles 1-3), fence at cycle 5, acks in cycles 10-12. Ready is expected at cycle 14.
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      tick();
      st_fire = (c <= 3); st_wid = 2'd1;
      ack_valid = (c >= 10 && c <= 12); ack_wid = 2'd1;
      if (c == 5) exp_q.push_back(14);
      fence_valid = (c >= 5) && !acc; fence_wid = 2'd1;
      @(negedge clk);
      chk("t2_nps", no_pending_stores, (c == 1 || c >= 13));
      mon();
    end
    chk("t2_fence_missing", exp_q.size(), 0);

    // Fence on warp 2 while warp 0 has 4 stores pending. Warp 2 is already empty.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick();
      st_fire = (c <= 4); st_wid = 2'd0;
      if (c == 6) exp_q.push_back(8);
      fence_valid = (c >= 6) && !acc; fence_wid = 2'd2;
      @(negedge clk);
      chk("t3_nps", no_pending_stores, (c == 1));
      mon();
    end
    chk("t3_fence_missing", exp_q.size(), 0);

    // 15 stores on warp 3 saturate its counter. A 16th store must overflow.
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      tick();
      st_fire = (c <= 16); st_wid = 2'd3;
      @(negedge clk);
      chk("t4_mask", st_stall_mask, (c >= 16) ? 4'b1000 : 4'b0000);
      chk("t4_ovf", err_overflow, (c >= 17));
      if (c >= 16) chk("t4_cnt3", dut.cnt[3], 15);
      mon();
    end

    // A store and an ack together at zero do nothing. A lone ack at zero underflows.
    do_reset();
    tick(); st_fire = 1; st_wid = 2'd0; ack_valid = 1; ack_wid = 2'd0;
    @(negedge clk);
    tick(); st_fire = 0; ack_valid = 1; ack_wid = 2'd0;
    @(negedge clk);
    chk("t5_cnt0_a", dut.cnt[0], 0);
    chk("t5_unf_a", err_underflow, 0);
    chk("t5_ovf_a", err_overflow, 0);
    chk("t5_nps_a", no_pending_stores, 1);
    tick(); ack_valid = 0;
    @(negedge clk);
    chk("t5_unf_b", err_underflow, 1);
    chk("t5_cnt0_b", dut.cnt[0], 0);
    chk("t5_ovf_b", err_overflow, 0);
    tick();
    @(negedge clk);
    chk("t5_unf_sticky", err_underflow, 1);

    // Reset in the middle of a fence that is draining 2 pending stores.
    do_reset();
    tick(); st_fire = 1; st_wid = 2'd1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick(); st_fire = 0; fence_valid = 1; fence_wid = 2'd1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_drain", dut.state, DRAIN);
    mon();
    tick(); reset = 1;
    @(negedge clk);
    chk("t6_nps_pre", no_pending_stores, 0);
    mon();
    tick(); reset = 0; fence_valid = 0;
    @(negedge clk);
    chk("t6_idle", dut.state, IDLE);
    chk("t6_nps", no_pending_stores, 1);
    chk("t6_ready", fence_ready, 0);
    chk("t6_cnt1", dut.cnt[1], 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      chk("t6_no_ready", fence_ready, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
